// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-2 types and helpers.
//   ahb_trans_t  - HTRANS encoding (IDLE/BUSY/NONSEQ/SEQ)
//   ahb_burst_t  - HBURST encoding (SINGLE..INCR16)
//   ahb_resp_t   - HRESP encoding (OKAY/ERROR/RETRY/SPLIT)
//   ahb_master_t - master index (up to 16 masters)
//   ahb_split_t  - split-resume vector, one bit per possible master
//   ahb_burst_len() - beats in a fixed-length burst (1..16)
package ahb_pkg;

  typedef enum logic [1:0] {
    AHB_IDLE   = 2'b00,
    AHB_BUSY   = 2'b01,
    AHB_NONSEQ = 2'b10,
    AHB_SEQ    = 2'b11
  } ahb_trans_t;

  typedef enum logic [2:0] {
    AHB_SINGLE = 3'd0,
    AHB_INCR   = 3'd1,
    AHB_WRAP4  = 3'd2,
    AHB_INCR4  = 3'd3,
    AHB_WRAP8  = 3'd4,
    AHB_INCR8  = 3'd5,
    AHB_WRAP16 = 3'd6,
    AHB_INCR16 = 3'd7
  } ahb_burst_t;

  typedef enum logic [1:0] {
    AHB_OKAY  = 2'b00,
    AHB_ERROR = 2'b01,
    AHB_RETRY = 2'b10,
    AHB_SPLIT = 2'b11
  } ahb_resp_t;

  typedef logic [3:0]  ahb_master_t;
  typedef logic [15:0] ahb_split_t;

  localparam int AHB_MAX_MASTERS = 16;

  // Undefined-length INCR counts as a single beat: it is not protected
  // against rearbitration.
  function automatic logic [4:0] ahb_burst_len(input ahb_burst_t burst);
    logic [4:0] len;
    case (burst)
      AHB_WRAP4, AHB_INCR4:   len = 5'd4;
      AHB_WRAP8, AHB_INCR8:   len = 5'd8;
      AHB_WRAP16, AHB_INCR16: len = 5'd16;
      default:                len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick: combinational requester selection.
//   req    - request vector
//   mask   - masters excluded from selection
//   ptr    - last granted index (round-robin starts at ptr+1)
//   policy - 0 = fixed priority (lowest index wins), 1 = round-robin
//   idx    - selected master index (0 when nothing eligible)
//   valid  - at least one eligible requester
module ahb_arb_pick
  import ahb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  ahb_master_t  ptr,
  input  logic         policy,
  output ahb_master_t  idx,
  output logic         valid
);

  logic [N-1:0] elig;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elig
      assign elig[gi] = req[gi] & ~mask[gi];
    end
  endgenerate

  // Each eligible master gets a distance; the smallest wins. For
  // round-robin the distance is how far past the pointer the index sits
  // (ptr+1 is distance 0, ptr itself is distance N-1).
  always_comb begin
    int best_d;
    int d;
    idx    = '0;
    valid  = 1'b0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      if (policy)
        d = (i + 2 * N - int'(ptr) - 1) % N;
      else
        d = i;
      if (elig[i] && (d < best_d)) begin
        best_d = d;
        idx    = ahb_master_t'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB-2 bus arbiter with burst protection, locking and SPLIT.
//   hclk, hreset - clock, asynchronous active-high reset
//   hbusreqx     - per-master bus request
//   hlockx       - per-master lock request
//   hsplitx      - split-resume vector (bits >= ARB_NUMBER ignored)
//   htrans, hburst, hready, hresp - current bus status
//   hgrantx      - one-hot grant
//   hmaster      - address-phase owner
//   hmastlock    - current address phase is locked
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int ARB_NUMBER = 4,
  parameter int DEF_MASTER = 0,
  parameter int ARB_POLICY = 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [ARB_NUMBER-1:0] hbusreqx,
  input  logic [ARB_NUMBER-1:0] hlockx,
  input  ahb_split_t            hsplitx,
  input  ahb_trans_t            htrans,
  input  ahb_burst_t            hburst,
  input  logic                  hready,
  input  ahb_resp_t             hresp,
  output logic [ARB_NUMBER-1:0] hgrantx,
  output ahb_master_t           hmaster,
  output logic                  hmastlock
);

  localparam ahb_master_t DEF_IDX   = ahb_master_t'(DEF_MASTER);
  localparam logic        POLICY_RR = (ARB_POLICY != 0);

  logic [ARB_NUMBER-1:0] hgrantx_reg;
  ahb_master_t           grant_idx_reg;   // index form of hgrantx_reg, also the RR pointer
  ahb_master_t           hmaster_reg;
  logic                  hmastlock_reg;
  ahb_master_t           hmaster_d_reg;   // data-phase owner
  logic [3:0]            rem_reg;         // beats left in the protected burst
  logic [ARB_NUMBER-1:0] split_mask_reg;

  logic [3:0]            rem_next;
  logic [ARB_NUMBER-1:0] split_next;
  logic [ARB_NUMBER-1:0] grant_next;
  logic [ARB_NUMBER-1:0] def_grant;
  ahb_master_t           pick_idx;
  ahb_master_t           next_idx;
  logic                  pick_valid;
  logic                  lock_sel;
  logic                  hold;
  logic                  split_resp;

  // Upper split lines beyond the populated masters have no effect.
  logic unused_hsplitx;
  assign unused_hsplitx = ^hsplitx;

  // Burst counter. An ERROR/RETRY/SPLIT first cycle (hready low) aborts
  // the burst so the bus can be rearbitrated on the second cycle.
  always_comb begin
    rem_next = rem_reg;
    if (hready) begin
      case (htrans)
        AHB_NONSEQ: rem_next = 4'(ahb_burst_len(hburst) - 5'd1);
        AHB_SEQ:    if (rem_reg != 4'd0) rem_next = rem_reg - 4'd1;
        AHB_BUSY:   rem_next = rem_reg;
        default:    rem_next = 4'd0;
      endcase
    end else if (hresp != AHB_OKAY) begin
      rem_next = 4'd0;
    end
  end

  // Lock request of whichever master currently holds the grant.
  assign lock_sel   = |(hlockx & hgrantx_reg);
  assign hold       = (rem_next != 4'd0) || lock_sel;
  assign split_resp = hready && (hresp == AHB_SPLIT);

  ahb_arb_pick #(
    .N (ARB_NUMBER)
  ) u_pick (
    .req    (hbusreqx),
    .mask   (split_mask_reg),
    .ptr    (grant_idx_reg),
    .policy (POLICY_RR),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign next_idx = pick_valid ? pick_idx : DEF_IDX;

  genvar gi;
  generate
    for (gi = 0; gi < ARB_NUMBER; gi++) begin : g_lane
      assign grant_next[gi] = (next_idx == ahb_master_t'(gi));
      assign def_grant[gi]  = (gi == DEF_MASTER);
      // A set on the split response beats a same-cycle resume.
      assign split_next[gi] = (split_resp && (hmaster_d_reg == ahb_master_t'(gi))) ||
                              (split_mask_reg[gi] && !hsplitx[gi]);
    end
  endgenerate

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hgrantx_reg    <= def_grant;
      grant_idx_reg  <= DEF_IDX;
      hmaster_reg    <= DEF_IDX;
      hmastlock_reg  <= 1'b0;
      hmaster_d_reg  <= DEF_IDX;
      rem_reg        <= 4'd0;
      split_mask_reg <= '0;
    end else begin
      rem_reg        <= rem_next;
      split_mask_reg <= split_next;
      if (hready) begin
        hmaster_reg   <= grant_idx_reg;
        hmastlock_reg <= lock_sel;
        hmaster_d_reg <= hmaster_reg;
        if (!hold) begin
          hgrantx_reg   <= grant_next;
          grant_idx_reg <= next_idx;
        end
      end
    end
  end

  assign hgrantx   = hgrantx_reg;
  assign hmaster   = hmaster_reg;
  assign hmastlock = hmastlock_reg;

endmodule
